// File: rtl/z80_irq_pkg.sv
// z80_irq_pkg: shared state encoding, interrupt-mode codes and default restart vectors
package z80_irq_pkg;
    typedef enum logic [1:0] {IDLE, ACK, TAKE} state_t;
    localparam logic [1:0] IM0 = 2'd0;
    localparam logic [1:0] IM1 = 2'd1;
    localparam logic [1:0] IM2 = 2'd2;
    localparam logic [15:0] NMI_VECTOR_DEF = 16'h0066;
    localparam logic [15:0] IM1_VECTOR_DEF = 16'h0038;
endpackage

// File: rtl/z80_nmi_edge.sv
// z80_nmi_edge: falling-edge detector on nmi_n with a sticky latch
//   clk, reset_n : clock, async active-low reset
//   nmi_n        : synchronised NMI pin (active-low)
//   clr          : clears the latch when the NMI is accepted
//   latch        : pending NMI
module z80_nmi_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic nmi_n,
    input  logic clr,
    output logic latch
);
    logic prev;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            prev  <= 1'b1;
            latch <= 1'b0;
        end else begin
            prev  <= nmi_n;
            // a fresh edge in the clearing cycle must not be lost
            latch <= (latch & ~clr) | (prev & ~nmi_n);
        end
endmodule

// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl: IFF1/IFF2/IM ownership, EI shadow, NMI/INT acceptance and acknowledge sequencing
//   clk, reset_n               : clock, async active-low reset
//   insn_done + insn_*         : instruction boundary pulse and retiring-instruction qualifiers
//   nmi_n, int_n               : interrupt pins (NMI falling-edge, INT level)
//   ack_ready, ack_done        : acknowledge handshake from the M-cycle sequencer
//   data_bus_vec, i_reg        : acknowledge byte and I register for vector formation
//   iff1, iff2, im             : architectural interrupt state
//   ack_req, ack_is_nmi        : acknowledge request and its kind
//   take_valid, take_vector,
//   take_im0_opcode            : one-cycle jump request to the core
module z80_irq_ctrl
    import z80_irq_pkg::*;
#(
    parameter logic [15:0] NMI_VECTOR = NMI_VECTOR_DEF,
    parameter logic [15:0] IM1_VECTOR = IM1_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        insn_done,
    input  logic        insn_ei,
    input  logic        insn_di,
    input  logic        insn_retn,
    input  logic        insn_im,
    input  logic [1:0]  insn_im_mode,
    input  logic        nmi_n,
    input  logic        int_n,
    input  logic        ack_ready,
    input  logic        ack_done,
    input  logic [7:0]  data_bus_vec,
    input  logic [7:0]  i_reg,
    output logic        iff1,
    output logic        iff2,
    output logic [1:0]  im,
    output logic        ack_req,
    output logic        ack_is_nmi,
    output logic        take_valid,
    output logic [15:0] take_vector,
    output logic        take_im0_opcode
);
    state_t     state, state_d;
    logic       ei_shadow, nmi_latch, clr;
    logic       iff1_d, iff2_d, sh_d, nmi_d, bnd, take_nmi, take_int, fin;
    logic [1:0] im_d;

    z80_nmi_edge u_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .nmi_n  (nmi_n),
        .clr    (clr),
        .latch  (nmi_latch)
    );

    assign bnd      = insn_done && state == IDLE;
    assign take_nmi = bnd && nmi_latch;
    assign take_int = bnd && !nmi_latch && !int_n && iff1 && !ei_shadow;
    assign fin      = state == ACK && ack_ready && ack_done;
    assign clr      = take_nmi;
    assign ack_req  = state == ACK;
    assign take_valid = state == TAKE;

    always_comb begin
        iff1_d  = iff1;
        iff2_d  = iff2;
        im_d    = im;
        sh_d    = ei_shadow;
        nmi_d   = ack_is_nmi;
        state_d = state == TAKE ? IDLE : fin ? TAKE : state;
        if (bnd) begin
            sh_d = insn_ei && !insn_di;
            if (insn_di) begin
                iff1_d = 1'b0;
                iff2_d = 1'b0;
            end else if (insn_ei) begin
                iff1_d = 1'b1;
                iff2_d = 1'b1;
            end else if (insn_retn)
                iff1_d = iff2;
            else if (insn_im)
                im_d = insn_im_mode == 2'd3 ? IM0 : insn_im_mode;
        end
        // acceptance overrides the retiring instruction's flag updates
        if (take_nmi) begin
            iff2_d  = iff1;
            iff1_d  = 1'b0;
            nmi_d   = 1'b1;
            state_d = ACK;
        end else if (take_int) begin
            iff1_d  = 1'b0;
            iff2_d  = 1'b0;
            nmi_d   = 1'b0;
            state_d = ACK;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state           <= IDLE;
            iff1            <= 1'b0;
            iff2            <= 1'b0;
            im              <= IM0;
            ei_shadow       <= 1'b0;
            ack_is_nmi      <= 1'b0;
            take_vector     <= 16'h0000;
            take_im0_opcode <= 1'b0;
        end else begin
            state      <= state_d;
            iff1       <= iff1_d;
            iff2       <= iff2_d;
            im         <= im_d;
            ei_shadow  <= sh_d;
            ack_is_nmi <= nmi_d;
            if (fin) begin
                take_vector     <= ack_is_nmi ? NMI_VECTOR : im == IM1 ? IM1_VECTOR :
                                   im == IM2 ? {i_reg, data_bus_vec[7:1], 1'b0} : 16'h0000;
                take_im0_opcode <= !ack_is_nmi && im == IM0;
            end
        end
endmodule

// File: tb/tb_z80_irq_ctrl.sv
// tb_z80_irq_ctrl: scoreboard bench for the interrupt-acceptance stage
module tb_z80_irq_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        insn_done = 0, insn_ei = 0, insn_di = 0, insn_retn = 0, insn_im = 0;
    logic [1:0]  insn_im_mode = 0;
    logic        nmi_n = 1, int_n = 1, ack_ready = 0, ack_done = 0;
    logic [7:0]  data_bus_vec = 0, i_reg = 0;
    logic        iff1, iff2, ack_req, ack_is_nmi, take_valid, take_im0_opcode;
    logic [1:0]  im;
    logic [15:0] take_vector;

    typedef struct packed {logic nmi; logic [15:0] vec; logic im0;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0, ack_cycles = 0;

    z80_irq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .insn_done(insn_done), .insn_ei(insn_ei),
        .insn_di(insn_di), .insn_retn(insn_retn), .insn_im(insn_im),
        .insn_im_mode(insn_im_mode), .nmi_n(nmi_n), .int_n(int_n),
        .ack_ready(ack_ready), .ack_done(ack_done), .data_bus_vec(data_bus_vec),
        .i_reg(i_reg), .iff1(iff1), .iff2(iff2), .im(im), .ack_req(ack_req),
        .ack_is_nmi(ack_is_nmi), .take_valid(take_valid), .take_vector(take_vector),
        .take_im0_opcode(take_im0_opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_n && ack_req) ack_cycles++;
        if (reset_n && take_valid) begin
            if (q.size() == 0) chk("unexpected_take", 16'd1, 16'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("take_is_nmi", {15'd0, ack_is_nmi}, {15'd0, e.nmi});
                chk("take_vector", take_vector, e.vec);
                chk("take_im0", {15'd0, take_im0_opcode}, {15'd0, e.im0});
            end
        end
    end

    task automatic bnd(input logic ei, input logic di, input logic retn, input logic imq, input logic [1:0] mode);
        @(negedge clk);
        insn_done = 1; insn_ei = ei; insn_di = di; insn_retn = retn; insn_im = imq; insn_im_mode = mode;
        @(negedge clk);
        insn_done = 0; insn_ei = 0; insn_di = 0; insn_retn = 0; insn_im = 0; insn_im_mode = 0;
    endtask

    task automatic nop();
        bnd(0, 0, 0, 0, 2'd0);
    endtask

    task automatic nmi_edge();
        @(negedge clk) nmi_n = 0;
        @(negedge clk) nmi_n = 1;
    endtask

    task automatic do_ack(input logic [7:0] d);
        int n = 0;
        while (!ack_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ack_req) chk("ack_timeout", 16'd0, 16'd1);
        else begin
            data_bus_vec = d; ack_ready = 1; ack_done = 1;
            @(negedge clk);
            ack_ready = 0; ack_done = 0; data_bus_vec = 8'hxx;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int snap;
        #100000 $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int snap;
        repeat (3) @(negedge clk);
        chk("rst_iff1", {15'd0, iff1}, 16'd0);
        chk("rst_iff2", {15'd0, iff2}, 16'd0);
        chk("rst_im", {14'd0, im}, 16'd0);
        chk("rst_ack_req", {15'd0, ack_req}, 16'd0);
        chk("rst_ack_is_nmi", {15'd0, ack_is_nmi}, 16'd0);
        chk("rst_take_valid", {15'd0, take_valid}, 16'd0);
        chk("rst_take_vector", take_vector, 16'd0);
        chk("rst_take_im0", {15'd0, take_im0_opcode}, 16'd0);
        reset_n = 1;

        bnd(0, 0, 0, 1, 2'd1);
        chk("im1_set", {14'd0, im}, 16'd1);
        bnd(1, 0, 0, 0, 2'd0);
        chk("ei_iff1", {15'd0, iff1}, 16'd1);
        chk("ei_iff2", {15'd0, iff2}, 16'd1);
        int_n = 0;
        nop();
        chk("shadow_blocks_int", {15'd0, ack_req}, 16'd0);
        nop();
        chk("int_ack_req", {15'd0, ack_req}, 16'd1);
        chk("int_iff1", {15'd0, iff1}, 16'd0);
        chk("int_iff2", {15'd0, iff2}, 16'd0);
        chk("int_kind", {15'd0, ack_is_nmi}, 16'd0);
        q.push_back('{nmi: 1'b0, vec: 16'h0038, im0: 1'b0});
        int_n = 1;
        do_ack(8'hFF);
        chk("im1_post_iff1", {15'd0, iff1}, 16'd0);

        bnd(0, 0, 0, 1, 2'd2);
        i_reg = 8'h12;
        bnd(1, 0, 0, 0, 2'd0);
        int_n = 0;
        nop();
        nop();
        q.push_back('{nmi: 1'b0, vec: 16'h1234, im0: 1'b0});
        int_n = 1;
        do_ack(8'h35);

        bnd(0, 0, 0, 1, 2'd3);
        chk("im3_maps_0", {14'd0, im}, 16'd0);
        bnd(1, 0, 0, 0, 2'd0);
        int_n = 0;
        nop();
        nop();
        q.push_back('{nmi: 1'b0, vec: 16'h0000, im0: 1'b1});
        int_n = 1;
        do_ack(8'hC7);

        bnd(1, 0, 0, 0, 2'd0);
        nmi_edge();
        nop();
        chk("nmi_kind", {15'd0, ack_is_nmi}, 16'd1);
        chk("nmi_iff1", {15'd0, iff1}, 16'd0);
        chk("nmi_iff2", {15'd0, iff2}, 16'd1);
        q.push_back('{nmi: 1'b1, vec: 16'h0066, im0: 1'b0});
        do_ack(8'h00);
        bnd(0, 0, 1, 0, 2'd0);
        chk("retn_iff1", {15'd0, iff1}, 16'd1);

        nmi_edge();
        int_n = 0;
        nop();
        chk("both_nmi_first", {15'd0, ack_is_nmi}, 16'd1);
        q.push_back('{nmi: 1'b1, vec: 16'h0066, im0: 1'b0});
        do_ack(8'hAA);
        snap = ack_cycles;
        nop();
        chk("int_blocked_after_nmi", {15'd0, ack_req}, 16'd0);
        chk("iff2_kept", {15'd0, iff2}, 16'd1);
        int_n = 1;
        bnd(0, 1, 0, 0, 2'd0);

        int_n = 0;
        snap = ack_cycles;
        bnd(1, 0, 0, 0, 2'd0);
        bnd(0, 1, 0, 0, 2'd0);
        nop();
        nop();
        chk("ei_di_no_ack", ack_cycles[15:0], snap[15:0]);
        chk("ei_di_iff1", {15'd0, iff1}, 16'd0);
        chk("ei_di_iff2", {15'd0, iff2}, 16'd0);

        bnd(0, 0, 0, 1, 2'd1);
        bnd(1, 0, 0, 0, 2'd0);
        nop();
        nop();
        chk("pre_reset_ack", {15'd0, ack_req}, 16'd1);
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("midack_ack_req", {15'd0, ack_req}, 16'd0);
        chk("midack_iff1", {15'd0, iff1}, 16'd0);
        chk("midack_iff2", {15'd0, iff2}, 16'd0);
        chk("midack_im", {14'd0, im}, 16'd0);
        chk("midack_take", {15'd0, take_valid}, 16'd0);
        int_n = 1;
        @(negedge clk) reset_n = 1;
        snap = ack_cycles;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", ack_cycles[15:0], snap[15:0]);
        chk("queue_empty", q.size(), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
